// File: rtl/r_fwft_stage_if.sv
// Read-side FIFO port plus the outgoing valid/ready stream of the FWFT stage.
// The slave modport is the stage itself; master is whatever surrounds it.
interface r_fwft_stage_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  r_empty_i;
  logic                  r_en_o;
  logic [DATA_WIDTH-1:0] r_data_i;
  logic [DATA_WIDTH-1:0] m_data_o;
  logic                  m_valid_o;
  logic                  m_ready_i;
  logic [1:0]            level_o;

  modport slave (
    input  r_empty_i,
    input  r_data_i,
    input  m_ready_i,
    output r_en_o,
    output m_data_o,
    output m_valid_o,
    output level_o
  );

  modport master (
    output r_empty_i,
    output r_data_i,
    output m_ready_i,
    input  r_en_o,
    input  m_data_o,
    input  m_valid_o,
    input  level_o
  );
endinterface

// File: rtl/r_fwft_stage.sv
// First-word-fall-through output stage: head + skid buffer in front of a
// RAM read port with one cycle of read latency.
module r_fwft_stage #(
  parameter int DATA_WIDTH = 8
) (
  input  logic           clk_r_i,
  input  logic           rst_r_ni,
  r_fwft_stage_if.slave  bus
);

  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  head_valid_q, head_valid_d;
  logic                  skid_valid_q, skid_valid_d;
  logic                  in_flight_q;

  logic [1:0] level;
  logic [1:0] credit_used;
  logic       pop;
  logic       fetch;

  assign level       = {1'b0, head_valid_q} + {1'b0, skid_valid_q};
  assign credit_used = level + {1'b0, in_flight_q};
  assign pop         = head_valid_q & bus.m_ready_i;

  // A pop this cycle frees a slot in time for data fetched now, so it also grants credit.
  assign fetch = rst_r_ni & ~bus.r_empty_i & ((credit_used < 2'd2) | pop);

  assign bus.r_en_o    = fetch;
  assign bus.m_data_o  = head_q;
  assign bus.m_valid_o = head_valid_q;
  assign bus.level_o   = level;

  always_comb begin
    head_d       = head_q;
    skid_d       = skid_q;
    head_valid_d = head_valid_q;
    skid_valid_d = skid_valid_q;
    if (in_flight_q) begin
      if (!head_valid_q || (pop && !skid_valid_q)) begin
        head_d       = bus.r_data_i;
        head_valid_d = 1'b1;
      end else if (!pop) begin
        skid_d       = bus.r_data_i;
        skid_valid_d = 1'b1;
      end else begin
        head_d = skid_q;
        skid_d = bus.r_data_i;
      end
    end else if (pop) begin
      if (skid_valid_q) begin
        head_d       = skid_q;
        skid_valid_d = 1'b0;
      end else begin
        head_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_r_i or negedge rst_r_ni) begin
    if (!rst_r_ni) begin
      head_q       <= '0;
      skid_q       <= '0;
      head_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_flight_q  <= 1'b0;
    end else begin
      head_q       <= head_d;
      skid_q       <= skid_d;
      head_valid_q <= head_valid_d;
      skid_valid_q <= skid_valid_d;
      in_flight_q  <= fetch;
    end
  end

endmodule

// File: tb/tb_r_fwft_stage.sv
// Self-checking bench for r_fwft_stage: behavioural RAM, level/credit model
// and a fetch-order scoreboard, plus a table of directed vectors.
module tb_r_fwft_stage;
  localparam int DW = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  r_fwft_stage_if #(.DATA_WIDTH(DW)) bus();

  r_fwft_stage #(.DATA_WIDTH(DW)) dut (
    .clk_r_i  (clk),
    .rst_r_ni (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [DW-1:0] sb[$];
  int            m_stored   = 0;
  bit            m_inflight = 1'b0;
  logic [DW-1:0] next_word  = '0;
  logic [DW-1:0] ram_word   = '0;
  bit            ram_pending = 1'b0;

  int            ren_count, pop_count, first_ren, first_pop, last_pop;
  logic [DW-1:0] last_pop_data;

  typedef struct {
    bit            e;
    bit            r;
    bit            ren;
    bit            v;
    logic [1:0]    lvl;
    bit            cd;
    logic [DW-1:0] d;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  task automatic clear_stats();
    ren_count = 0; pop_count = 0; first_ren = -1; first_pop = -1; last_pop = -1;
    last_pop_data = '0;
  endtask

  // One clock cycle: drive on the falling edge, sample 1 ns later, update model on the rising edge.
  task automatic step(input bit empty, input bit ready,
                      output bit s_ren, output bit s_valid,
                      output logic [1:0] s_lvl, output logic [DW-1:0] s_data);
    bit exp_valid, exp_pop, exp_ren;
    @(negedge clk);
    bus.r_empty_i = empty;
    bus.m_ready_i = ready;
    bus.r_data_i  = ram_pending ? ram_word : DW'($urandom);
    #1;
    exp_valid = (m_stored > 0);
    exp_pop   = exp_valid & ready;
    exp_ren   = !empty && (((m_stored + int'(m_inflight)) < 2) || exp_pop);
    chk("r_en", bus.r_en_o, exp_ren);
    chk("m_valid", bus.m_valid_o, exp_valid);
    chk("level", bus.level_o, m_stored);
    chk("r_en_while_empty", bus.r_en_o & empty, 0);
    if (exp_valid && sb.size() > 0) chk("m_data", bus.m_data_o, sb[0]);
    s_ren   = bus.r_en_o;
    s_valid = bus.m_valid_o;
    s_lvl   = bus.level_o;
    s_data  = bus.m_data_o;
    @(posedge clk);
    chk("arrival_at_full_no_pop", (m_inflight && m_stored == 2 && !exp_pop), 0);
    m_stored = m_stored + int'(m_inflight) - int'(exp_pop);
    if (exp_pop && sb.size() > 0) void'(sb.pop_front());
    if (s_valid && ready) begin
      pop_count++;
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
      last_pop_data = s_data;
    end
    m_inflight  = s_ren;
    ram_pending = s_ren;
    if (s_ren) begin
      ren_count++;
      if (first_ren < 0) first_ren = cyc;
      ram_word = next_word;
      sb.push_back(next_word);
      next_word = next_word + 1'b1;
    end
    cyc++;
  endtask

  task automatic run(input bit empty, input bit ready);
    bit a, b; logic [1:0] l; logic [DW-1:0] d;
    step(empty, ready, a, b, l, d);
  endtask

  // Assert reset asynchronously mid-cycle, check outputs at once, release just after a rising edge.
  task automatic apply_reset(input bit empty_during);
    @(negedge clk);
    bus.r_empty_i = empty_during;
    bus.m_ready_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_r_en", bus.r_en_o, 0);
    chk("rst_m_valid", bus.m_valid_o, 0);
    chk("rst_level", bus.level_o, 0);
    chk("rst_m_data", bus.m_data_o, 0);
    sb.delete();
    m_stored = 0; m_inflight = 1'b0; ram_pending = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_r_en", bus.r_en_o, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    bit s_ren, s_valid; logic [1:0] s_lvl; logic [DW-1:0] s_data;

    tbl[0]  = '{0, 0, 1, 0, 2'd0, 0, 8'h00};
    tbl[1]  = '{0, 0, 1, 0, 2'd0, 0, 8'h00};
    tbl[2]  = '{0, 0, 0, 1, 2'd1, 1, 8'h00};
    for (int i = 3; i <= 9; i++) tbl[i] = '{0, 0, 0, 1, 2'd2, 1, 8'h00};
    tbl[10] = '{0, 1, 1, 1, 2'd2, 1, 8'h00};
    tbl[11] = '{0, 1, 1, 1, 2'd1, 1, 8'h01};
    tbl[12] = '{0, 1, 1, 1, 2'd1, 1, 8'h02};
    tbl[13] = '{1, 1, 0, 1, 2'd1, 1, 8'h03};
    tbl[14] = '{1, 1, 0, 1, 2'd1, 1, 8'h04};
    tbl[15] = '{1, 1, 0, 0, 2'd0, 0, 8'h00};

    bus.r_empty_i = 1'b0;
    bus.m_ready_i = 1'b0;
    bus.r_data_i  = '0;
    clear_stats();

    // Power-up reset with the FIFO non-empty, then release into the directed table.
    apply_reset(1'b0);
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].e, tbl[i].r, s_ren, s_valid, s_lvl, s_data);
      chk($sformatf("vec%0d_r_en", i), s_ren, tbl[i].ren);
      chk($sformatf("vec%0d_valid", i), s_valid, tbl[i].v);
      chk($sformatf("vec%0d_level", i), s_lvl, tbl[i].lvl);
      if (tbl[i].cd) chk($sformatf("vec%0d_data", i), s_data, tbl[i].d);
    end
    chk("backpressure_ren_pulses", ren_count, 5);

    // Single word.
    clear_stats();
    next_word = 8'hA5;
    run(1'b0, 1'b1);
    repeat (4) run(1'b1, 1'b1);
    chk("single_ren_pulses", ren_count, 1);
    chk("single_pops", pop_count, 1);
    chk("single_data", last_pop_data, 8'hA5);
    chk("single_latency", first_pop - first_ren, 2);
    step(1'b1, 1'b1, s_ren, s_valid, s_lvl, s_data);
    chk("single_end_level", s_lvl, 0);

    // Streaming 16 words back to back.
    clear_stats();
    next_word = 8'h00;
    repeat (16) run(1'b0, 1'b1);
    repeat (6) run(1'b1, 1'b1);
    chk("stream_ren_pulses", ren_count, 16);
    chk("stream_pops", pop_count, 16);
    chk("stream_first_latency", first_pop - first_ren, 2);
    chk("stream_no_gaps", last_pop - first_pop, 15);
    chk("stream_last_data", last_pop_data, 8'h0F);

    // Random empty and ready against the model.
    for (int i = 0; i < 400; i++) run($urandom_range(0, 99) < 30, $urandom_range(0, 1) == 1);
    repeat (4) run(1'b1, 1'b1);
    chk("random_drained", sb.size(), 0);

    // Reset while the buffer is full.
    next_word = 8'h40;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, s_ren, s_valid, s_lvl, s_data);
    chk("prereset_level", s_lvl, 2);
    apply_reset(1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, s_ren, s_valid, s_lvl, s_data);
      chk($sformatf("postreset_valid%0d", i), s_valid, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
